// File: rtl/rename_map_freelist.sv
// Single-issue register rename: speculative RAT, bitmap free list, registered results.
// Optional RENAME_FLUSH_EN adds a committed RAT/busy map restored on flush.
module rename_map_freelist #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int RETIRE_W  = 2,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(PHYS_REGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ren_valid,
  output logic                   ren_ready,
  input  logic [AW-1:0]          ren_src1,
  input  logic [AW-1:0]          ren_src2,
  input  logic [AW-1:0]          ren_dst,
  input  logic                   ren_has_dst,
  output logic                   out_valid,
  output logic [PW-1:0]          out_src1_p,
  output logic [PW-1:0]          out_src2_p,
  output logic [PW-1:0]          out_dst_p,
  output logic [PW-1:0]          out_old_p,
  output logic                   out_old_valid,
  output logic [CW-1:0]          free_count,
  input  logic [RETIRE_W-1:0]    retire_valid,
  input  logic [RETIRE_W*PW-1:0] retire_old_p,
  input  logic [RETIRE_W*AW-1:0] retire_dst,
  input  logic [RETIRE_W*PW-1:0] retire_new_p,
  input  logic                   flush
);
  localparam int MAX_FREE = PHYS_REGS - ARCH_REGS;
  localparam logic [PHYS_REGS-1:0] FREE_INIT = {PHYS_REGS{1'b1}} << ARCH_REGS;

  logic [PW-1:0]        rat [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_bits, freed, free_bits_nxt;
  logic [PW-1:0]        alloc_p;
  logic                 alloc_req, accept, alloc, flush_now;
  logic [CW-1:0]        free_count_nxt;

  function automatic logic [CW-1:0] sat_count(input int v);
    if (v < 0) return '0;
    if (v > MAX_FREE) return CW'(MAX_FREE);
    return CW'(v);
  endfunction

  function automatic int popcount(input logic [PHYS_REGS-1:0] v);
    int n = 0;
    for (int i = 0; i < PHYS_REGS; i++) n += int'(v[i]);
    return n;
  endfunction

`ifdef RENAME_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
  logic unused_flush_inputs;
  assign unused_flush_inputs = ^{flush, retire_dst, retire_new_p};
`endif

  assign alloc_req = ren_has_dst && (ren_dst != '0);
  assign ren_ready = ((free_count != '0) || !alloc_req) && !flush_now;
  assign accept    = ren_valid && ren_ready;
  assign alloc     = accept && alloc_req;

  // Lowest-index free register wins.
  always_comb begin
    alloc_p = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--)
      if (free_bits[i]) alloc_p = PW'(i);
  end

  // Only busy, non-zero pregs count as freed; duplicates collapse in the mask.
  always_comb begin
    freed = '0;
    for (int l = 0; l < RETIRE_W; l++)
      if (retire_valid[l] && (retire_old_p[l*PW +: PW] != '0))
        freed[retire_old_p[l*PW +: PW]] = 1'b1;
    freed = freed & ~free_bits;
    free_bits_nxt = free_bits | freed;
    if (alloc) free_bits_nxt[alloc_p] = 1'b0;
    free_count_nxt = sat_count(int'(free_count) - int'(alloc) + popcount(freed));
  end

`ifdef RENAME_FLUSH_EN
  logic [PW-1:0]        crat [ARCH_REGS];
  logic [PW-1:0]        crat_nxt [ARCH_REGS];
  logic [PHYS_REGS-1:0] cbusy, cbusy_nxt;

  // Committed state after this cycle's retirements; later lanes override earlier ones.
  always_comb begin
    crat_nxt  = crat;
    cbusy_nxt = cbusy;
    for (int l = 0; l < RETIRE_W; l++)
      if (retire_valid[l]) begin
        if (retire_dst[l*AW +: AW] != '0)
          crat_nxt[retire_dst[l*AW +: AW]] = retire_new_p[l*PW +: PW];
        cbusy_nxt[retire_new_p[l*PW +: PW]] = 1'b1;
        if (retire_old_p[l*PW +: PW] != '0)
          cbusy_nxt[retire_old_p[l*PW +: PW]] = 1'b0;
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) crat[i] <= PW'(i);
      cbusy <= ~FREE_INIT;
    end else begin
      crat  <= crat_nxt;
      cbusy <= cbusy_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PW'(i);
      free_bits     <= FREE_INIT;
      free_count    <= CW'(MAX_FREE);
      out_valid     <= 1'b0;
      out_src1_p    <= '0;
      out_src2_p    <= '0;
      out_dst_p     <= '0;
      out_old_p     <= '0;
      out_old_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_src1_p <= rat[ren_src1];
        out_src2_p <= rat[ren_src2];
        if (alloc) begin
          out_dst_p     <= alloc_p;
          out_old_p     <= rat[ren_dst];
          out_old_valid <= 1'b1;
          rat[ren_dst]  <= alloc_p;
        end else begin
          out_dst_p     <= rat[ren_dst];
          out_old_valid <= 1'b0;
        end
      end
      free_bits  <= free_bits_nxt;
      free_count <= free_count_nxt;
`ifdef RENAME_FLUSH_EN
      if (flush) begin
        rat        <= crat_nxt;
        free_bits  <= ~cbusy_nxt;
        free_count <= sat_count(popcount(~cbusy_nxt));
      end
`endif
    end
  end
endmodule
